seg_scroll_decoder: RTL and testbench

- Receive-side counterpart to the scrolling 7-segment message driver: samples the multiplexed anode/segment lines, rebuilds the 4-digit frame and decodes each digit to a character code.
- Detects one-digit left scrolls and emits the newly entered character as a one-cycle strobe.
- Used as an on-board loopback checker and bench monitor for the display path; runs on the system clock, asynchronous to the driver's clocks.

---
 rtl/seg_scroll_decoder_pkg.sv | 50 +++++
 rtl/seg_scroll_decoder_if.sv | 22 ++
 rtl/seg_scroll_decoder_glyph_decode.sv | 29 ++
 rtl/seg_scroll_decoder.sv | 144 ++++++++++++++
 tb/tb_seg_scroll_decoder.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/seg_scroll_decoder_pkg.sv
// Shared constants for the scrolling 7-segment path: glyphs, character codes, anode patterns.
// Imported by the decoder, its glyph lookup and the driver bench.
package seg_scroll_decoder_pkg;

  localparam int unsigned SEG_W  = 7;
  localparam int unsigned AN_W   = 4;
  localparam int unsigned CODE_W = 5;
  localparam int unsigned SLOTS  = 4;

  typedef logic [CODE_W-1:0]            code_t;
  typedef logic [SLOTS-1:0][CODE_W-1:0] frame_t;

  // Active-low glyphs, bit6=g ... bit0=a
  localparam logic [SEG_W-1:0] SEG_SPACE = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_W_CH  = 7'b1010101;
  localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_L     = 7'b1000111;
  localparam logic [SEG_W-1:0] SEG_C     = 7'b1000110;
  localparam logic [SEG_W-1:0] SEG_O     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_M     = 7'b1101010;
  localparam logic [SEG_W-1:0] SEG_T     = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_S     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_I     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_N     = 7'b1001000;
  localparam logic [SEG_W-1:0] SEG_A     = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_Y     = 7'b0010001;

  localparam code_t CODE_SPACE   = 5'd0;
  localparam code_t CODE_W_CH    = 5'd1;
  localparam code_t CODE_E       = 5'd2;
  localparam code_t CODE_L       = 5'd3;
  localparam code_t CODE_C       = 5'd4;
  localparam code_t CODE_O       = 5'd5;
  localparam code_t CODE_M       = 5'd6;
  localparam code_t CODE_T       = 5'd7;
  localparam code_t CODE_S       = 5'd8;
  localparam code_t CODE_I       = 5'd9;
  localparam code_t CODE_N       = 5'd10;
  localparam code_t CODE_A       = 5'd11;
  localparam code_t CODE_Y       = 5'd12;
  localparam code_t CODE_UNKNOWN = 5'd31;

  // Active-low one-hot anodes; slot0 is the rightmost digit
  localparam logic [AN_W-1:0] AN_SLOT0 = 4'b1110;
  localparam logic [AN_W-1:0] AN_SLOT1 = 4'b1101;
  localparam logic [AN_W-1:0] AN_SLOT2 = 4'b1011;
  localparam logic [AN_W-1:0] AN_SLOT3 = 4'b0111;
  localparam logic [AN_W-1:0] AN_BLANK = 4'b1111;

endpackage

// File: rtl/seg_scroll_decoder_if.sv
// Display-line and decoded-result bundle between a 7-segment driver and the decoder.
interface seg_scroll_decoder_if;
  import seg_scroll_decoder_pkg::*;

  logic [AN_W-1:0]  an;
  logic [SEG_W-1:0] seg;
  frame_t           frame_code;
  logic             frame_valid;
  code_t            char_code;
  logic             char_valid;
  logic             err_glitch;

  modport master (
    output an, seg,
    input  frame_code, frame_valid, char_code, char_valid, err_glitch
  );

  modport slave (
    input  an, seg,
    output frame_code, frame_valid, char_code, char_valid, err_glitch
  );
endinterface

// File: rtl/seg_scroll_decoder_glyph_decode.sv
// Combinational active-low 7-segment glyph to 5-bit character code lookup.
module seg_glyph_decode
  import seg_scroll_decoder_pkg::*;
(
  input  logic [SEG_W-1:0] i_seg,
  output code_t            o_code_c
);

  always_comb begin
    o_code_c = CODE_UNKNOWN;
    case (i_seg)
      SEG_SPACE: o_code_c = CODE_SPACE;
      SEG_W_CH:  o_code_c = CODE_W_CH;
      SEG_E:     o_code_c = CODE_E;
      SEG_L:     o_code_c = CODE_L;
      SEG_C:     o_code_c = CODE_C;
      SEG_O:     o_code_c = CODE_O;
      SEG_M:     o_code_c = CODE_M;
      SEG_T:     o_code_c = CODE_T;
      SEG_S:     o_code_c = CODE_S;
      SEG_I:     o_code_c = CODE_I;
      SEG_N:     o_code_c = CODE_N;
      SEG_A:     o_code_c = CODE_A;
      SEG_Y:     o_code_c = CODE_Y;
      default:   o_code_c = CODE_UNKNOWN;
    endcase
  end

endmodule

// File: rtl/seg_scroll_decoder.sv
// Rebuilds the multiplexed 4-digit frame from anode/segment lines, filters torn frames
// and reports committed frames plus the character shifted in on a left scroll.
module seg_scroll_decoder
  import seg_scroll_decoder_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  seg_scroll_decoder_if.slave  bus
);

  localparam int unsigned       CNT_W   = 8;
  localparam logic [CNT_W-1:0]  CNT_TGT = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  logic [SYNC_STAGES-1:0][AN_W-1:0]  r_an_sync;
  logic [SYNC_STAGES-1:0][SEG_W-1:0] r_seg_sync;
  logic [AN_W-1:0]                   r_an_prev;
  logic [SEG_W-1:0]                  r_seg_prev;
  logic [CNT_W-1:0]                  r_cnt;
  logic [SLOTS-1:0]                  r_mask;
  frame_t                            r_cand;
  frame_t                            r_prev_cand;
  frame_t                            r_frame_code;
  code_t                             r_char_code;
  logic                              r_frame_valid;
  logic                              r_char_valid;
  logic                              r_err_glitch;

  logic [AN_W-1:0]  w_an;
  logic [SEG_W-1:0] w_seg;
  logic             w_slot_valid;
  logic             w_illegal;
  logic [1:0]       w_slot;
  logic             w_same;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_accept;
  code_t            w_code;
  frame_t           w_cand_upd;
  logic [SLOTS-1:0] w_mask_upd;
  logic             w_frame_done;
  logic             w_commit;
  logic             w_scroll;

  // Input synchronisers; idle lines are high so reset to ones
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_an_sync  <= '1;
      r_seg_sync <= '1;
    end else begin
      r_an_sync  <= {r_an_sync[SYNC_STAGES-2:0], bus.an};
      r_seg_sync <= {r_seg_sync[SYNC_STAGES-2:0], bus.seg};
    end
  end

  assign w_an  = r_an_sync[SYNC_STAGES-1];
  assign w_seg = r_seg_sync[SYNC_STAGES-1];

  always_comb begin
    w_slot_valid = 1'b0;
    w_illegal    = 1'b0;
    w_slot       = 2'd0;
    case (w_an)
      AN_SLOT0: begin w_slot_valid = 1'b1; w_slot = 2'd0; end
      AN_SLOT1: begin w_slot_valid = 1'b1; w_slot = 2'd1; end
      AN_SLOT2: begin w_slot_valid = 1'b1; w_slot = 2'd2; end
      AN_SLOT3: begin w_slot_valid = 1'b1; w_slot = 2'd3; end
      AN_BLANK: ;
      default:  w_illegal = 1'b1;
    endcase
  end

  seg_glyph_decode u_glyph (
    .i_seg    (w_seg),
    .o_code_c (w_code)
  );

  // Dwell counter; accepting on the transition into the target fires once per dwell
  assign w_same    = ({w_an, w_seg} == {r_an_prev, r_seg_prev});
  assign w_cnt_nxt = (w_same && !w_illegal)
                   ? ((r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1))
                   : '0;
  assign w_accept  = w_slot_valid && (w_cnt_nxt == CNT_TGT) && (r_cnt != CNT_TGT);

  always_comb begin
    w_cand_upd         = r_cand;
    w_cand_upd[w_slot] = w_code;
    w_mask_upd         = r_mask | (SLOTS'(1) << w_slot);
  end

  // Commit only when two consecutive complete frames agree and differ from the output
  assign w_frame_done = w_accept && (w_mask_upd == '1);
  assign w_commit     = w_frame_done && (w_cand_upd == r_prev_cand)
                        && (w_cand_upd != r_frame_code);
  assign w_scroll     = (w_cand_upd[3:1] == r_frame_code[2:0]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_an_prev     <= '1;
      r_seg_prev    <= '1;
      r_cnt         <= '0;
      r_mask        <= '0;
      r_cand        <= '0;
      r_prev_cand   <= '0;
      r_frame_code  <= '0;
      r_char_code   <= '0;
      r_frame_valid <= 1'b0;
      r_char_valid  <= 1'b0;
      r_err_glitch  <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      r_char_valid  <= 1'b0;
      r_err_glitch  <= w_illegal;
      r_an_prev     <= w_an;
      r_seg_prev    <= w_seg;
      r_cnt         <= w_cnt_nxt;
      if (w_accept) begin
        r_cand <= w_cand_upd;
        r_mask <= w_mask_upd;
      end
      if (w_frame_done) begin
        r_prev_cand <= w_cand_upd;
        r_mask      <= '0;
      end
      if (w_commit) begin
        r_frame_code  <= w_cand_upd;
        r_frame_valid <= 1'b1;
        if (w_scroll) begin
          r_char_valid <= 1'b1;
          r_char_code  <= w_cand_upd[0];
        end
      end
    end
  end

  assign bus.frame_code  = r_frame_code;
  assign bus.frame_valid = r_frame_valid;
  assign bus.char_code   = r_char_code;
  assign bus.char_valid  = r_char_valid;
  assign bus.err_glitch  = r_err_glitch;

endmodule

// File: tb/tb_seg_scroll_decoder.sv
// Directed bench for seg_scroll_decoder: drives multiplexed frames and checks commits,
// scroll strobes, tear filtering, glitch reporting and reset behaviour.
module tb_seg_scroll_decoder;
  import seg_scroll_decoder_pkg::*;

  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;
  int   fv_cnt;
  int   cv_cnt;
  int   er_cnt;
  int   fv0;
  int   cv0;
  int   er0;

  seg_scroll_decoder_if bus ();

  seg_scroll_decoder #(
    .STABLE_CYCLES (4),
    .SYNC_STAGES   (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pulse counters, sampled away from the active edge
  initial begin
    fv_cnt = 0;
    cv_cnt = 0;
    er_cnt = 0;
  end
  always @(negedge clock) begin
    if (bus.frame_valid === 1'b1) fv_cnt <= fv_cnt + 1;
    if (bus.char_valid  === 1'b1) cv_cnt <= cv_cnt + 1;
    if (bus.err_glitch  === 1'b1) er_cnt <= er_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_slot(input logic [3:0] a, input logic [6:0] s, input int n);
    bus.an  = a;
    bus.seg = s;
    repeat (n) @(negedge clock);
  endtask

  task automatic drive_frame(input logic [6:0] g3, input logic [6:0] g2,
                             input logic [6:0] g1, input logic [6:0] g0, input int d0);
    drive_slot(AN_SLOT3, g3, 8);
    drive_slot(AN_SLOT2, g2, 8);
    drive_slot(AN_SLOT1, g1, 8);
    drive_slot(AN_SLOT0, g0, d0);
  endtask

  task automatic settle();
    drive_slot(AN_BLANK, SEG_SPACE, 8);
  endtask

  task automatic snap();
    fv0 = fv_cnt;
    cv0 = cv_cnt;
    er0 = er_cnt;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    bus.an      = AN_BLANK;
    bus.seg     = SEG_SPACE;
    repeat (3) @(negedge clock);
    check("rst_frame_code",  32'(bus.frame_code),  32'h0);
    check("rst_frame_valid", 32'(bus.frame_valid), 32'h0);
    check("rst_char_code",   32'(bus.char_code),   32'h0);
    check("rst_char_valid",  32'(bus.char_valid),  32'h0);
    check("rst_err_glitch",  32'(bus.err_glitch),  32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // One W frame alone must not commit
    snap();
    drive_frame(SEG_SPACE, SEG_SPACE, SEG_SPACE, SEG_W_CH, 8);
    settle();
    check("w_first_fv", 32'(fv_cnt - fv0), 32'd0);

    snap();
    drive_frame(SEG_SPACE, SEG_SPACE, SEG_SPACE, SEG_W_CH, 8);
    settle();
    check("w_fv",         32'(fv_cnt - fv0),   32'd1);
    check("w_cv",         32'(cv_cnt - cv0),   32'd1);
    check("w_char_code",  32'(bus.char_code),  32'd1);
    check("w_frame_code", 32'(bus.frame_code), 32'h00001);

    snap();
    drive_frame(SEG_SPACE, SEG_SPACE, SEG_W_CH, SEG_E, 8);
    drive_frame(SEG_SPACE, SEG_SPACE, SEG_W_CH, SEG_E, 8);
    settle();
    check("e_fv",         32'(fv_cnt - fv0),   32'd1);
    check("e_cv",         32'(cv_cnt - cv0),   32'd1);
    check("e_char_code",  32'(bus.char_code),  32'd2);
    check("e_frame_code", 32'(bus.frame_code), 32'h00022);

    snap();
    drive_frame(SEG_SPACE, SEG_SPACE, SEG_W_CH, SEG_E, 8);
    settle();
    check("repeat_fv", 32'(fv_cnt - fv0), 32'd0);
    check("repeat_cv", 32'(cv_cnt - cv0), 32'd0);

    // {7,5,0,8} is not a shift of {0,0,1,2}
    snap();
    drive_frame(SEG_T, SEG_O, SEG_SPACE, SEG_S, 8);
    drive_frame(SEG_T, SEG_O, SEG_SPACE, SEG_S, 8);
    settle();
    check("tos_fv",         32'(fv_cnt - fv0),   32'd1);
    check("tos_cv",         32'(cv_cnt - cv0),   32'd0);
    check("tos_frame_code", 32'(bus.frame_code), 32'h39408);
    check("tos_char_code",  32'(bus.char_code),  32'd2);

    snap();
    drive_frame(SEG_W_CH, SEG_E, SEG_L, SEG_C, 8);
    drive_frame(SEG_S, SEG_I, SEG_N, SEG_A, 8);
    settle();
    check("tear_fv",         32'(fv_cnt - fv0),   32'd0);
    check("tear_frame_code", 32'(bus.frame_code), 32'h39408);

    snap();
    drive_slot(4'b1100, SEG_SPACE, 3);
    settle();
    check("glitch_err",        32'(er_cnt - er0),   32'd3);
    check("glitch_fv",         32'(fv_cnt - fv0),   32'd0);
    check("glitch_frame_code", 32'(bus.frame_code), 32'h39408);

    // Slot0 dwell of STABLE_CYCLES-1 never completes a frame
    snap();
    drive_frame(SEG_SPACE, SEG_SPACE, SEG_SPACE, SEG_W_CH, 3);
    drive_frame(SEG_SPACE, SEG_SPACE, SEG_SPACE, SEG_W_CH, 3);
    settle();
    check("short_fv",         32'(fv_cnt - fv0),   32'd0);
    check("short_frame_code", 32'(bus.frame_code), 32'h39408);
    check("short_err",        32'(er_cnt - er0),   32'd0);

    snap();
    drive_frame(SEG_SPACE, SEG_SPACE, SEG_SPACE, 7'b0000000, 8);
    drive_frame(SEG_SPACE, SEG_SPACE, SEG_SPACE, 7'b0000000, 8);
    settle();
    check("unk_fv",         32'(fv_cnt - fv0),   32'd1);
    check("unk_cv",         32'(cv_cnt - cv0),   32'd0);
    check("unk_frame_code", 32'(bus.frame_code), 32'h0001F);

    // Reset in the middle of a frame
    drive_slot(AN_SLOT3, SEG_W_CH, 8);
    drive_slot(AN_SLOT2, SEG_E, 4);
    reset   = 1'b1;
    bus.an  = AN_BLANK;
    bus.seg = SEG_SPACE;
    repeat (2) @(negedge clock);
    check("mid_rst_frame_code",  32'(bus.frame_code),  32'h0);
    check("mid_rst_frame_valid", 32'(bus.frame_valid), 32'h0);
    check("mid_rst_char_valid",  32'(bus.char_valid),  32'h0);
    check("mid_rst_char_code",   32'(bus.char_code),   32'h0);
    snap();
    reset = 1'b0;
    drive_frame(SEG_SPACE, SEG_SPACE, SEG_SPACE, 7'b0000000, 8);
    settle();
    check("post_rst_fv",         32'(fv_cnt - fv0),   32'd0);
    check("post_rst_cv",         32'(cv_cnt - cv0),   32'd0);
    check("post_rst_frame_code", 32'(bus.frame_code), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
